inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (word index = byte address [11:2]).
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-005 SHALL have port rx_valid  input  1  byte-stream valid.
REQ-006 SHALL have port rx_data  input  8  byte-stream data.
REQ-007 SHALL have port rx_ready  output  1  byte-stream ready; a byte transfers when rx_valid and rx_ready are both 1.
REQ-008 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-009 SHALL have port wr_addr  output  ADDR_W  instruction-memory word index.
REQ-010 SHALL have port wr_data  output  32  instruction word.
REQ-011 SHALL have port cpu_hold  output  1  held high to freeze PC and fetch while loading.
REQ-012 SHALL have ports busy, done and err, each output  1: session active; one-cycle completion pulse; sticky error.

Function
REQ-013 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE.
REQ-014 IDLE SHALL go to LEN_LO on start=1, clear err, set busy and cpu_hold; start is ignored in all other states.
REQ-015 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CHK, and 0 in IDLE and DONE.
REQ-016 LEN_LO/LEN_HI SHALL capture a 16-bit little-endian word count N.
REQ-017 N=0 or N>2^ADDR_W SHALL set err and go to DONE with no writes.
REQ-018 DATA SHALL assemble 4 bytes little-endian (first byte = bits [7:0]); wr_en SHALL pulse in the cycle after the 4th byte transfers, with wr_data = the word and wr_addr = word index, starting at 0.
REQ-019 The word index SHALL increment after each write; after write N-1 the block SHALL go to CHK when LOADER_CHECKSUM_EN is defined, else to DONE.
REQ-020 Bytes with rx_valid=0 SHALL stall without changing state; gaps of any length are legal.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; busy and cpu_hold SHALL drop to 0 in the DONE cycle.
REQ-022 err SHALL stay set until the next accepted start or reset.
REQ-023 With N=2^ADDR_W the final write SHALL use wr_addr = 2^ADDR_W-1 and the index SHALL NOT wrap into a further write.

Reset
REQ-024 reset=1 at any clock edge, including mid-session, SHALL force IDLE and drive rx_ready, wr_en, cpu_hold, busy, done and err to 0, and wr_addr and wr_data to 0; a partial word SHALL be discarded.

Configuration
REQ-025 Macro LOADER_CHECKSUM_EN: when defined, CHK SHALL accept one byte and compare it with the XOR of all data bytes; a mismatch SHALL set err. Data writes SHALL NOT be undone. When undefined, CHK SHALL be unreachable and no checksum byte is consumed.

Structure
REQ-026 Package inst_loader_pkg SHALL hold the state enumeration, the default ADDR_W and the header length constant (2 bytes).
REQ-027 Sub-module byte_packer SHALL own the 4-byte shift and byte counter, and SHALL output a word-complete flag.

Verification
REQ-028 The bench SHALL cover: start; bytes 02 00, 78 56 34 12, EF BE AD DE -> wr_en at addr 0 with 0x12345678 and at addr 1 with 0xDEADBEEF; done pulses once; err=0.
REQ-029 The bench SHALL cover, with LOADER_CHECKSUM_EN: N=1 with data 01 02 03 04 and checksum 04 -> err=0; the same stream with checksum 05 -> err=1, and the write still occurs.
REQ-030 The bench SHALL cover: header 00 00 -> err=1, done pulses, and wr_en is never asserted.
REQ-031 The bench SHALL cover: reset asserted after 2 data bytes -> next cycle in IDLE with cpu_hold=0; a new session writes addr 0 correctly.
REQ-032 The bench SHALL cover: random rx_valid gaps (0-5 cycles) and a start pulse during DATA -> the same writes as a gapless run, with the start ignored.
REQ-033 The bench SHALL cover: N=1024 with ADDR_W=10 -> the last write goes to addr 1023, exactly 1024 wr_en pulses occur, and err=0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader:
// FSM state encoding, default address width and header length.
package inst_loader_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int HDR_LEN    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_DONE
  } state_t;

  // States in which the loader is consuming the byte stream.
  function automatic logic rx_state(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Assembles four consecutive bytes into a little-endian 32-bit word and
// flags the word in the cycle after its fourth byte arrives.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  assign byte_last = byte_valid && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = byte_last;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (byte_valid) begin
      // Shift right so the first byte ends up in bits [7:0].
      word_d = {byte_data, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          HDR_BITS  = HDR_LEN * 8;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [HDR_BITS-1:0] n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rx_ready_q, rx_ready_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          chk_q, chk_d;
`endif

  logic                xfer, start_ok, pk_valid, pk_last, pk_word_valid, last_word;
  logic [31:0]         pk_word;
  logic [HDR_BITS-1:0] hdr_n;

  assign xfer      = rx_valid && rx_ready_q;
  assign start_ok  = (state_q == ST_IDLE) && start;
  assign pk_valid  = xfer && (state_q == ST_DATA);
  assign hdr_n     = {rx_data, n_q[7:0]};
  assign last_word = (32'(idx_q) == 32'(n_q) - 32'd1);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .byte_last  (pk_last),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    if (pk_word_valid) idx_d = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LEN_LO;
          err_d   = 1'b0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = 8'd0;
`endif
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          n_d     = {{(HDR_BITS-8){1'b0}}, rx_data};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          n_d = hdr_n;
          if ((hdr_n == '0) || (32'(hdr_n) > MAX_WORDS)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) chk_d = chk_q ^ rx_data;
        if (pk_last && last_word) state_d = ST_CHK;
`else
        // Leave on the final byte so no further byte is pulled into the packer.
        if (pk_last && last_word) state_d = ST_DONE;
`endif
      end
      ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          if (rx_data != chk_q) err_d = 1'b1;
          state_d = ST_DONE;
        end
`else
        state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = rx_state(state_d);
    busy_d     = rx_state(state_d);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_ready_q <= rx_ready_d;
`ifdef LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = pk_word_valid;
  assign wr_addr  = idx_q;
  assign wr_data  = pk_word;
  assign cpu_hold = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader; checksum scenarios run
// only when LOADER_CHECKSUM_EN is defined.
module tb_inst_mem_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, wr_en, cpu_hold, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  int          done_busy_bad = 0;
  int          log_addr[$];
  logic [31:0] log_data[$];
  logic [7:0]  chk_acc;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      if (busy || cpu_hold) done_busy_bad++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w = 0;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && w < 20) begin
      tick();
      w++;
    end
    check("rx_ready_before_byte", 32'(rx_ready), 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] word, input int gap_max);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = word[8*i +: 8];
      chk_acc ^= b;
      send_byte(b, (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_chk;
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk_acc, 0);
`endif
  endtask

  task automatic start_session;
    log_addr.delete();
    log_data.delete();
    chk_acc   = 8'd0;
    done_base = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w = 0;
    while (done_cnt == done_base && w < 50) begin
      tick();
      w++;
    end
    repeat (3) tick();
    check({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
    $display("[TB] session %s: writes=%0d err=%0b", tag, log_data.size(), err);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    reset = 1'b0;
    tick();

    // Two-word load
    start_session();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cpu_hold", 32'(cpu_hold), 32'd1);
    check("t1_rx_ready", 32'(rx_ready), 32'd1);
    send_hdr(16'd2);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_chk();
    wait_done("two_words");
    check("t1_nwrites", 32'(log_data.size()), 32'd2);
    check("t1_addr0", 32'(log_addr[0]), 32'd0);
    check("t1_data0", log_data[0], 32'h1234_5678);
    check("t1_addr1", 32'(log_addr[1]), 32'd1);
    check("t1_data1", log_data[1], 32'hDEAD_BEEF);
    check("t1_err", 32'(err), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_rx_ready", 32'(rx_ready), 32'd0);

    // Zero-length header
    start_session();
    send_hdr(16'd0);
    wait_done("n_zero");
    check("t2_err", 32'(err), 32'd1);
    check("t2_nwrites", 32'(log_data.size()), 32'd0);
    repeat (4) tick();
    check("t2_err_sticky", 32'(err), 32'd1);

    // Oversized header (1025 words)
    start_session();
    check("t2b_err_cleared", 32'(err), 32'd0);
    send_hdr(16'd1025);
    wait_done("n_too_big");
    check("t2b_err", 32'(err), 32'd1);
    check("t2b_nwrites", 32'(log_data.size()), 32'd0);

    // Reset in the middle of a word, then a clean session
    start_session();
    send_hdr(16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    tick();
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_cpu_hold", 32'(cpu_hold), 32'd0);
    check("t3_rx_ready", 32'(rx_ready), 32'd0);
    check("t3_err", 32'(err), 32'd0);
    check("t3_wr_data", wr_data, 32'd0);
    reset = 1'b0;
    tick();
    start_session();
    send_hdr(16'd1);
    send_word(32'hCAFE_F00D, 0);
    send_chk();
    wait_done("after_reset");
    check("t3_nwrites", 32'(log_data.size()), 32'd1);
    check("t3_addr0", 32'(log_addr[0]), 32'd0);
    check("t3_data0", log_data[0], 32'hCAFE_F00D);

    // Random gaps and an ignored start during DATA
    start_session();
    send_hdr(16'd3);
    send_word(32'h1122_3344, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_busy_after_start", 32'(busy), 32'd1);
    send_word(32'h5566_7788, 5);
    send_word(32'h99AA_BBCC, 5);
    send_chk();
    wait_done("gaps");
    check("t4_nwrites", 32'(log_data.size()), 32'd3);
    check("t4_addr0", 32'(log_addr[0]), 32'd0);
    check("t4_data0", log_data[0], 32'h1122_3344);
    check("t4_addr1", 32'(log_addr[1]), 32'd1);
    check("t4_data1", log_data[1], 32'h5566_7788);
    check("t4_addr2", 32'(log_addr[2]), 32'd2);
    check("t4_data2", log_data[2], 32'h99AA_BBCC);
    check("t4_err", 32'(err), 32'd0);

    // Full memory: 1024 words
    start_session();
    send_hdr(16'd1024);
    for (int i = 0; i < 1024; i++) send_word({16'(i), ~16'(i)}, 0);
    send_chk();
    wait_done("full_mem");
    check("t5_nwrites", 32'(log_data.size()), 32'd1024);
    check("t5_last_addr", 32'(log_addr[log_addr.size()-1]), 32'd1023);
    check("t5_last_data", log_data[log_data.size()-1], {16'd1023, ~16'd1023});
    begin
      int bad = 0;
      for (int i = 0; i < log_data.size(); i++)
        if (log_addr[i] != i || log_data[i] !== {16'(i), ~16'(i)}) bad++;
      check("t5_sequence_errors", 32'(bad), 32'd0);
    end
    check("t5_err", 32'(err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    start_session();
    send_hdr(16'd1);
    send_word(32'h0403_0201, 0);
    send_byte(8'h04, 0);
    wait_done("chk_good");
    check("c1_err", 32'(err), 32'd0);
    check("c1_nwrites", 32'(log_data.size()), 32'd1);
    check("c1_data", log_data[0], 32'h0403_0201);

    start_session();
    send_hdr(16'd1);
    send_word(32'h0403_0201, 0);
    send_byte(8'h05, 0);
    wait_done("chk_bad");
    check("c2_err", 32'(err), 32'd1);
    check("c2_nwrites", 32'(log_data.size()), 32'd1);
    check("c2_data", log_data[0], 32'h0403_0201);
`endif

    check("done_while_busy", 32'(done_busy_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
